// File: rtl/rsv_station_pkg.sv
// rtl/rsv_station_pkg.sv - shared word/tag/opcode types and station sizing
package rsv_station_pkg;

  localparam int WORD_W     = 32;
  localparam int ROB_TAG_W  = 4;
  localparam int OPT_CODE_W = 6;
  localparam int RS_SIZE    = 16;
  localparam int RS_IDX_W   = $clog2(RS_SIZE);

  typedef logic [WORD_W-1:0]     WORD_TP;
  typedef logic [ROB_TAG_W-1:0]  ROB_IDX_TP;
  typedef logic [OPT_CODE_W-1:0] INST_OPT_TP;
  typedef logic [RS_IDX_W-1:0]   RS_IDX_TP;

  localparam ROB_IDX_TP ZERO_ROB_IDX = '0;
  localparam WORD_TP    ZERO_WORD    = '0;
  localparam logic      TRUE         = 1'b1;
  localparam logic      FALSE        = 1'b0;

endpackage

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder over a request vector
module rs_pick
  import rsv_station_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = FALSE;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = W'(i);
        o_found = TRUE;
      end
    end
  end

endmodule

// File: rtl/rsv_station.sv
// rtl/rsv_station.sv - ALU reservation station: buffer, CDB wakeup, in-order-by-index issue
module rsv_station
  import rsv_station_pkg::*;
#(
  parameter int RS_SIZE   = 16,
  parameter int ROB_IDX_W = 4,
  parameter int OPT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rb,
  output logic                 full,
  input  logic                 disp_ena,
  input  logic [OPT_W-1:0]     disp_opt,
  input  logic [ROB_IDX_W-1:0] disp_src1,
  input  logic [ROB_IDX_W-1:0] disp_src2,
  input  WORD_TP               disp_val1,
  input  WORD_TP               disp_val2,
  input  WORD_TP               disp_imm,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  input  logic                 cdb_alu_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_src,
  input  WORD_TP               cdb_alu_val,
  input  logic                 cdb_ld_valid,
  input  logic [ROB_IDX_W-1:0] cdb_ld_src,
  input  WORD_TP               cdb_ld_val,
  output logic                 alu_ena,
  output logic [OPT_W-1:0]     alu_opt,
  output WORD_TP               alu_val1,
  output WORD_TP               alu_val2,
  output WORD_TP               alu_imm,
  output logic [ROB_IDX_W-1:0] alu_rob_idx
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [ROB_IDX_W-1:0] TAG0 = '0;

  logic [RS_SIZE-1:0]   r_busy;
  logic [OPT_W-1:0]     r_opt  [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_src1 [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_src2 [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_rob  [RS_SIZE];
  WORD_TP               r_val1 [RS_SIZE];
  WORD_TP               r_val2 [RS_SIZE];
  WORD_TP               r_imm  [RS_SIZE];

  logic [RS_SIZE-1:0]   w_free;
  logic [RS_SIZE-1:0]   w_ready;
  logic [IDX_W:0]       w_free_cnt;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_iss_idx;
  logic                 w_free_found;
  logic                 w_iss_found;
  logic [ROB_IDX_W-1:0] w_wr_src1;
  logic [ROB_IDX_W-1:0] w_wr_src2;
  WORD_TP               w_wr_val1;
  WORD_TP               w_wr_val2;

  function automatic logic cdb_hit(input logic [ROB_IDX_W-1:0] tag, input logic vld,
                                   input logic [ROB_IDX_W-1:0] src);
    return vld && (tag != TAG0) && (tag == src);
  endfunction

  assign w_free = ~r_busy;

  always_comb begin
    w_ready    = '0;
    w_free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && (r_src1[i] == TAG0) && (r_src2[i] == TAG0);
      if (!r_busy[i]) w_free_cnt = w_free_cnt + (IDX_W + 1)'(1);
    end
  end

  // One write may already be in flight from dispatch, so flag full with one slot left.
  assign full = (w_free_cnt <= (IDX_W + 1)'(1));

  always_comb begin
    w_wr_src1 = disp_src1;
    w_wr_val1 = disp_val1;
    w_wr_src2 = disp_src2;
    w_wr_val2 = disp_val2;
    if (cdb_hit(disp_src1, cdb_alu_valid, cdb_alu_src)) begin
      w_wr_src1 = TAG0;
      w_wr_val1 = cdb_alu_val;
    end else if (cdb_hit(disp_src1, cdb_ld_valid, cdb_ld_src)) begin
      w_wr_src1 = TAG0;
      w_wr_val1 = cdb_ld_val;
    end
    if (cdb_hit(disp_src2, cdb_alu_valid, cdb_alu_src)) begin
      w_wr_src2 = TAG0;
      w_wr_val2 = cdb_alu_val;
    end else if (cdb_hit(disp_src2, cdb_ld_valid, cdb_ld_src)) begin
      w_wr_src2 = TAG0;
      w_wr_val2 = cdb_ld_val;
    end
  end

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_free (
    .i_req   (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_issue (
    .i_req   (w_ready),
    .o_idx   (w_iss_idx),
    .o_found (w_iss_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      alu_ena     <= FALSE;
      alu_opt     <= '0;
      alu_val1    <= ZERO_WORD;
      alu_val2    <= ZERO_WORD;
      alu_imm     <= ZERO_WORD;
      alu_rob_idx <= '0;
    end else if (!rdy) begin
      alu_ena <= FALSE;
    end else if (rb) begin
      r_busy  <= '0;
      alu_ena <= FALSE;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          if (cdb_hit(r_src1[i], cdb_alu_valid, cdb_alu_src)) begin
            r_src1[i] <= TAG0;
            r_val1[i] <= cdb_alu_val;
          end else if (cdb_hit(r_src1[i], cdb_ld_valid, cdb_ld_src)) begin
            r_src1[i] <= TAG0;
            r_val1[i] <= cdb_ld_val;
          end
          if (cdb_hit(r_src2[i], cdb_alu_valid, cdb_alu_src)) begin
            r_src2[i] <= TAG0;
            r_val2[i] <= cdb_alu_val;
          end else if (cdb_hit(r_src2[i], cdb_ld_valid, cdb_ld_src)) begin
            r_src2[i] <= TAG0;
            r_val2[i] <= cdb_ld_val;
          end
        end
      end

      alu_ena <= w_iss_found;
      if (w_iss_found) begin
        r_busy[w_iss_idx] <= FALSE;
        alu_opt           <= r_opt[w_iss_idx];
        alu_val1          <= r_val1[w_iss_idx];
        alu_val2          <= r_val2[w_iss_idx];
        alu_imm           <= r_imm[w_iss_idx];
        alu_rob_idx       <= r_rob[w_iss_idx];
      end

      // The free slot is never the issuing slot, so these writes cannot collide.
      if (disp_ena && w_free_found) begin
        r_busy[w_free_idx] <= TRUE;
        r_opt[w_free_idx]  <= disp_opt;
        r_src1[w_free_idx] <= w_wr_src1;
        r_src2[w_free_idx] <= w_wr_src2;
        r_val1[w_free_idx] <= w_wr_val1;
        r_val2[w_free_idx] <= w_wr_val2;
        r_imm[w_free_idx]  <= disp_imm;
        r_rob[w_free_idx]  <= disp_rob_idx;
      end
    end
  end

endmodule

// File: tb/tb_rsv_station.sv
// tb/tb_rsv_station.sv - directed and randomized checks of rsv_station against a reference model
module tb_rsv_station;

  localparam int N  = 16;
  localparam int TW = 4;
  localparam int OW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, rb, full, disp_ena;
  logic [OW-1:0] disp_opt;
  logic [TW-1:0] disp_src1, disp_src2, disp_rob_idx;
  logic [31:0]   disp_val1, disp_val2, disp_imm;
  logic          cdb_alu_valid, cdb_ld_valid;
  logic [TW-1:0] cdb_alu_src, cdb_ld_src;
  logic [31:0]   cdb_alu_val, cdb_ld_val;
  logic          alu_ena;
  logic [OW-1:0] alu_opt;
  logic [31:0]   alu_val1, alu_val2, alu_imm;
  logic [TW-1:0] alu_rob_idx;

  rsv_station #(.RS_SIZE(N), .ROB_IDX_W(TW), .OPT_W(OW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .full(full),
    .disp_ena(disp_ena), .disp_opt(disp_opt), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_val1(disp_val1), .disp_val2(disp_val2), .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src), .cdb_ld_val(cdb_ld_val),
    .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx)
  );

  typedef struct {
    bit            busy;
    logic [OW-1:0] opt;
    logic [TW-1:0] s1, s2, rob;
    logic [31:0]   v1, v2, imm;
  } ent_t;

  ent_t          m [N];
  logic          m_ena;
  logic [OW-1:0] m_opt;
  logic [31:0]   m_v1, m_v2, m_imm;
  logic [TW-1:0] m_rob;
  int            m_iss, m_fr;
  int            tests = 0;
  int            fails = 0;
  bit            checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void resolve(input logic [TW-1:0] t, input logic [31:0] v,
                                  output logic [TW-1:0] nt, output logic [31:0] nv);
    nt = t;
    nv = v;
    if (t != 0) begin
      if (cdb_alu_valid && cdb_alu_src == t) begin nt = 0; nv = cdb_alu_val; end
      else if (cdb_ld_valid && cdb_ld_src == t) begin nt = 0; nv = cdb_ld_val; end
    end
  endfunction

  function automatic logic model_full();
    int f = 0;
    for (int i = 0; i < N; i++) if (!m[i].busy) f++;
    return f <= 1;
  endfunction

  // Reference model: one step per clock edge, from the station's documented rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_ena = 0; m_opt = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_rob = 0;
    end else if (!rdy) begin
      m_ena = 0;
    end else if (rb) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_ena = 0;
    end else begin
      m_iss = -1;
      m_fr  = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (m[i].busy && m[i].s1 == 0 && m[i].s2 == 0) m_iss = i;
        if (!m[i].busy) m_fr = i;
      end
      for (int i = 0; i < N; i++) begin
        if (m[i].busy) begin
          resolve(m[i].s1, m[i].v1, m[i].s1, m[i].v1);
          resolve(m[i].s2, m[i].v2, m[i].s2, m[i].v2);
        end
      end
      m_ena = (m_iss >= 0);
      if (m_iss >= 0) begin
        m_opt = m[m_iss].opt; m_v1 = m[m_iss].v1; m_v2 = m[m_iss].v2;
        m_imm = m[m_iss].imm; m_rob = m[m_iss].rob;
        m[m_iss].busy = 0;
      end
      if (disp_ena) begin
        chk("protocol_free_slot", (m_fr >= 0) ? 32'd1 : 32'd0, 32'd1);
        if (m_fr >= 0) begin
          m[m_fr].busy = 1; m[m_fr].opt = disp_opt; m[m_fr].imm = disp_imm;
          m[m_fr].rob = disp_rob_idx;
          resolve(disp_src1, disp_val1, m[m_fr].s1, m[m_fr].v1);
          resolve(disp_src2, disp_val2, m[m_fr].s2, m[m_fr].v2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("alu_ena", alu_ena, m_ena);
      chk("alu_opt", alu_opt, m_opt);
      chk("alu_val1", alu_val1, m_v1);
      chk("alu_val2", alu_val2, m_v2);
      chk("alu_imm", alu_imm, m_imm);
      chk("alu_rob_idx", alu_rob_idx, m_rob);
      chk("full", full, model_full());
    end
  end

  task automatic idle_in();
    rst = 0; rdy = 1; rb = 0; disp_ena = 0;
    disp_opt = 0; disp_src1 = 0; disp_src2 = 0; disp_rob_idx = 0;
    disp_val1 = 0; disp_val2 = 0; disp_imm = 0;
    cdb_alu_valid = 0; cdb_alu_src = 0; cdb_alu_val = 0;
    cdb_ld_valid = 0; cdb_ld_src = 0; cdb_ld_val = 0;
  endtask

  task automatic disp(input logic [TW-1:0] s1, input logic [TW-1:0] s2,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [TW-1:0] rob);
    disp_ena = 1; disp_src1 = s1; disp_src2 = s2; disp_val1 = v1; disp_val2 = v2;
    disp_rob_idx = rob; disp_opt = OW'(6'h01); disp_imm = v1 ^ 32'h0000_0F00;
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  logic last_full, cur_full;
  int   nw;

  initial begin
    idle_in();
    rst = 1;
    repeat (2) nc();
    rst = 0;
    checking = 1;
    chk("reset_ena", alu_ena, 0);
    chk("reset_full", full, 0);
    chk("reset_val1", alu_val1, 0);
    chk("reset_rob", alu_rob_idx, 0);

    // ready on write
    disp(0, 0, 32'd5, 32'd7, 4'd3);
    nc(); idle_in();
    nc();
    chk("row_ena", alu_ena, 1); chk("row_val1", alu_val1, 5);
    chk("row_val2", alu_val2, 7); chk("row_rob", alu_rob_idx, 3);
    nc();
    chk("row_freed", alu_ena, 0);

    // wakeup through the load channel
    disp(4'd2, 0, 32'd0, 32'd9, 4'd5);
    nc(); idle_in();
    nc(); chk("ld_wait", alu_ena, 0);
    cdb_ld_valid = 1; cdb_ld_src = 4'd2; cdb_ld_val = 32'h1234;
    nc(); idle_in();
    chk("ld_c1", alu_ena, 0);
    nc();
    chk("ld_ena", alu_ena, 1); chk("ld_val1", alu_val1, 32'h1234);
    chk("ld_val2", alu_val2, 9); chk("ld_rob", alu_rob_idx, 5);

    // same-cycle snoop on both channels, ALU wins
    disp(4'd4, 0, 32'd0, 32'h33, 4'd6);
    cdb_alu_valid = 1; cdb_alu_src = 4'd4; cdb_alu_val = 32'hAA;
    cdb_ld_valid = 1; cdb_ld_src = 4'd4; cdb_ld_val = 32'hBB;
    nc(); idle_in();
    nc();
    chk("snoop_ena", alu_ena, 1); chk("snoop_val1", alu_val1, 32'hAA);
    nc();

    // fill with one-cycle-late view of full
    last_full = full; nw = 0;
    for (int k = 0; k < 20; k++) begin
      cur_full = full;
      if (!last_full) begin disp(4'd1, 0, 32'd0, 32'(k), TW'(nw)); nw++; end
      else disp_ena = 0;
      last_full = cur_full;
      nc();
    end
    idle_in();
    chk("fill_writes", nw, 16);
    chk("fill_full", full, 1);
    cdb_alu_valid = 1; cdb_alu_src = 4'd1; cdb_alu_val = 32'h100;
    nc(); idle_in();
    chk("fill_bc_lat", alu_ena, 0);
    for (int j = 0; j < 16; j++) begin
      nc();
      chk("fill_ena", alu_ena, 1);
      chk("fill_order", alu_rob_idx, 32'(j));
      chk("fill_val1", alu_val1, 32'h100);
    end
    nc();
    chk("fill_drained", alu_ena, 0); chk("fill_empty_full", full, 0);

    // rollback mid-fill
    for (int k = 0; k < 5; k++) begin disp(4'd1, 0, 0, 0, TW'(8 + k)); nc(); end
    disp(0, 0, 32'h5, 32'h6, 4'd13); rb = 1;
    nc(); idle_in();
    chk("rb_full", full, 0); chk("rb_ena", alu_ena, 0);
    cdb_alu_valid = 1; cdb_alu_src = 4'd1; cdb_alu_val = 32'h7;
    nc(); idle_in();
    chk("rb_no_issue1", alu_ena, 0);
    nc();
    chk("rb_no_issue2", alu_ena, 0);

    // rdy low freezes issue and wakeup
    disp(4'd6, 0, 0, 32'h11, 4'd8);
    nc();
    disp(0, 0, 32'h21, 32'h22, 4'd7);
    nc(); idle_in();
    rdy = 0; cdb_alu_valid = 1; cdb_alu_src = 4'd6; cdb_alu_val = 32'h66;
    for (int k = 0; k < 3; k++) begin nc(); chk("rdy_hold", alu_ena, 0); end
    idle_in();
    nc();
    chk("rdy_resume_ena", alu_ena, 1); chk("rdy_resume_rob", alu_rob_idx, 7);
    cdb_alu_valid = 1; cdb_alu_src = 4'd6; cdb_alu_val = 32'h77;
    nc(); idle_in();
    chk("rdy_nowake", alu_ena, 0);
    nc();
    chk("rdy_late_ena", alu_ena, 1); chk("rdy_late_val1", alu_val1, 32'h77);
    chk("rdy_late_rob", alu_rob_idx, 8);

    // randomized traffic
    last_full = full;
    for (int c = 0; c < 3000; c++) begin
      cur_full = full;
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      rb  = ($urandom_range(0, 59) == 0);
      disp_ena = !last_full && ($urandom_range(0, 2) != 0);
      disp_opt = OW'($urandom_range(0, 63));
      disp_src1 = TW'($urandom_range(0, 3));
      disp_src2 = TW'($urandom_range(0, 3));
      disp_val1 = $urandom; disp_val2 = $urandom; disp_imm = $urandom;
      disp_rob_idx = TW'($urandom_range(0, 15));
      cdb_alu_valid = ($urandom_range(0, 1) == 1);
      cdb_alu_src = TW'($urandom_range(1, 4)); cdb_alu_val = $urandom;
      cdb_ld_valid = ($urandom_range(0, 1) == 1);
      cdb_ld_src = TW'($urandom_range(1, 4)); cdb_ld_val = $urandom;
      last_full = cur_full;
      nc();
    end
    idle_in();
    repeat (3) nc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
